key_word_transform: RTL



---
 rtl/key_sched_pkg.sv | 32 +++
 rtl/sbox_lane.sv | 28 ++
 rtl/key_word_transform.sv | 103 ++++++++++
 3 files changed

// File: rtl/key_sched_pkg.sv
// Shared constants for the AES key-schedule word transform: S-box table,
// GF(2^8) doubling and mode encoding.
package key_sched_pkg;

   localparam logic [7:0] RCON_INIT_DEFAULT = 8'h01;
   localparam logic       MODE_G            = 1'b0;
   localparam logic       MODE_H            = 1'b1;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/sbox_lane.sv
// One byte lane of the S-box pipeline: lookup registered in the first stage,
// then SBOX_LAT-1 further delay stages, all frozen while en is low.
module sbox_lane
   import key_sched_pkg::*;
#(
   parameter int SBOX_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] plain,
   output logic [7:0] subst
);

   logic [7:0] stage [SBOX_LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SBOX_LAT; i++) stage[i] <= '0;
      end else if (en) begin
         stage[0] <= SBOX[plain];
         for (int i = 1; i < SBOX_LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign subst = stage[SBOX_LAT-1];

endmodule

// File: rtl/key_word_transform.sv
// Key-schedule word transform (g / h function) with internal round-constant
// generation and a fully stalling valid/ready pipeline.
module key_word_transform
   import key_sched_pkg::*;
#(
   parameter int         SBOX_LAT  = 1,
   parameter logic [7:0] RCON_INIT = RCON_INIT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] word_in,
   input  logic        mode_h,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] word_out,
   output logic [7:0]  rcon_used
);

   localparam int LAST = SBOX_LAT - 1;

   logic                  stall;
   logic                  accept;
   logic [7:0]            rcon_q;
   logic [7:0]            rcon_eff;
   logic [SBOX_LAT-1:0]   valid_pipe;
   logic [SBOX_LAT-1:0]   mode_pipe;
   logic [7:0]            rcon_pipe [SBOX_LAT];
   logic [3:0][7:0]       sub_bytes;
   logic [31:0]           word_next;
   logic [7:0]            rcon_next;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;
   assign accept   = in_valid & in_ready;
   assign rcon_eff = start ? RCON_INIT : rcon_q;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      sbox_lane #(.SBOX_LAT(SBOX_LAT)) u_lane (
         .clk   (clk),
         .rst   (rst),
         .en    (~stall),
         .plain (word_in[8*g +: 8]),
         .subst (sub_bytes[g])
      );
   end

   // Sideband rides next to the lanes; when not stalled, in_valid equals accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_pipe <= '0;
         mode_pipe  <= '0;
         for (int i = 0; i < SBOX_LAT; i++) rcon_pipe[i] <= '0;
      end else if (!stall) begin
         valid_pipe[0] <= in_valid;
         mode_pipe[0]  <= mode_h;
         rcon_pipe[0]  <= rcon_eff;
         for (int i = 1; i < SBOX_LAT; i++) begin
            valid_pipe[i] <= valid_pipe[i-1];
            mode_pipe[i]  <= mode_pipe[i-1];
            rcon_pipe[i]  <= rcon_pipe[i-1];
         end
      end
   end

   // A start coinciding with a g-word is folded in through rcon_eff.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcon_q <= RCON_INIT;
      end else if (accept && (mode_h == MODE_G)) begin
         rcon_q <= xtime(rcon_eff);
      end else if (start) begin
         rcon_q <= RCON_INIT;
      end
   end

   always_comb begin
      rcon_next = 8'h00;
      word_next = {sub_bytes[3], sub_bytes[2], sub_bytes[1], sub_bytes[0]};
      if (mode_pipe[LAST] == MODE_G) begin
         rcon_next = rcon_pipe[LAST];
         word_next = {sub_bytes[2] ^ rcon_pipe[LAST], sub_bytes[1], sub_bytes[0], sub_bytes[3]};
      end
   end

   // Data only reloads on a real word so word_out keeps the last result across bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         word_out  <= '0;
         rcon_used <= '0;
      end else if (!stall) begin
         out_valid <= valid_pipe[LAST];
         if (valid_pipe[LAST]) begin
            word_out  <= word_next;
            rcon_used <= rcon_next;
         end
      end
   end

endmodule
